// File: rtl/zynq_axil_to_axi3_bridge.sv
// Single-beat AXI-Lite slave to AXI3 master bridge with a runtime base offset.
// One transaction in flight; write/read arbitration alternates when both are pending.
module zynq_axil_to_axi3_bridge #(
  parameter int         S_ADDR_WIDTH_P = 30,
  parameter int         M_ADDR_WIDTH_P = 32,
  parameter int         DATA_WIDTH_P   = 32,
  parameter logic [5:0] ID_P           = 6'd0
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [M_ADDR_WIDTH_P-1:0]   base_addr_i,
  output logic                        busy_o,
  input  logic [S_ADDR_WIDTH_P-1:0]   s_axi_awaddr,
  input  logic [2:0]                  s_axi_awprot,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [DATA_WIDTH_P-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH_P/8-1:0]   s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [S_ADDR_WIDTH_P-1:0]   s_axi_araddr,
  input  logic [2:0]                  s_axi_arprot,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [DATA_WIDTH_P-1:0]     s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic [M_ADDR_WIDTH_P-1:0]   m_axi_awaddr,
  output logic                        m_axi_awvalid,
  output logic [5:0]                  m_axi_awid,
  output logic [1:0]                  m_axi_awlock,
  output logic [3:0]                  m_axi_awcache,
  output logic [2:0]                  m_axi_awprot,
  output logic [3:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic [3:0]                  m_axi_awqos,
  input  logic                        m_axi_awready,
  output logic [DATA_WIDTH_P-1:0]     m_axi_wdata,
  output logic                        m_axi_wvalid,
  output logic [5:0]                  m_axi_wid,
  output logic                        m_axi_wlast,
  output logic [DATA_WIDTH_P/8-1:0]   m_axi_wstrb,
  input  logic                        m_axi_wready,
  input  logic                        m_axi_bvalid,
  input  logic [5:0]                  m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  output logic                        m_axi_bready,
  output logic [M_ADDR_WIDTH_P-1:0]   m_axi_araddr,
  output logic                        m_axi_arvalid,
  output logic [5:0]                  m_axi_arid,
  output logic [1:0]                  m_axi_arlock,
  output logic [3:0]                  m_axi_arcache,
  output logic [2:0]                  m_axi_arprot,
  output logic [3:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic [3:0]                  m_axi_arqos,
  input  logic                        m_axi_arready,
  input  logic [DATA_WIDTH_P-1:0]     m_axi_rdata,
  input  logic                        m_axi_rvalid,
  input  logic [5:0]                  m_axi_rid,
  input  logic                        m_axi_rlast,
  input  logic [1:0]                  m_axi_rresp,
  output logic                        m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, WR_DONE, RD_REQ, RD_RESP, RD_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic                        last_wr_q, last_wr_d;
  logic [M_ADDR_WIDTH_P-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH_P-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH_P/8-1:0]   wstrb_q, wstrb_d;
  logic                        aw_pend_q, aw_pend_d;
  logic                        w_pend_q, w_pend_d;
  logic [1:0]                  resp_q, resp_d;
  logic [DATA_WIDTH_P-1:0]     rdata_q, rdata_d;
  logic                        grant_wr, grant_rd;
  logic                        unused_prot;

  // Master-side protection is fixed; host prot bits are intentionally ignored.
  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      resp_q    <= 2'b00;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    case (state_q)
      IDLE: begin
        // Write needs both address and data present; ties go opposite to the last grant.
        grant_wr = s_axi_awvalid & s_axi_wvalid & (~s_axi_arvalid | ~last_wr_q);
        grant_rd = s_axi_arvalid & ~grant_wr;
        if (grant_wr) begin
          addr_d    = base_addr_i + M_ADDR_WIDTH_P'(s_axi_awaddr);
          wdata_d   = s_axi_wdata;
          wstrb_d   = s_axi_wstrb;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = WR_REQ;
        end else if (grant_rd) begin
          addr_d  = base_addr_i + M_ADDR_WIDTH_P'(s_axi_araddr);
          state_d = RD_REQ;
        end
      end
      WR_REQ: begin
        if (m_axi_awready) aw_pend_d = 1'b0;
        if (m_axi_wready)  w_pend_d  = 1'b0;
        if ((~aw_pend_q | m_axi_awready) & (~w_pend_q | m_axi_wready)) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          resp_d  = (m_axi_bid == ID_P) ? m_axi_bresp : 2'b10;
          state_d = WR_DONE;
        end
      end
      WR_DONE: begin
        if (s_axi_bready) begin
          last_wr_d = 1'b1;
          state_d   = IDLE;
        end
      end
      RD_REQ: begin
        if (m_axi_arready) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          resp_d  = ((m_axi_rid == ID_P) && m_axi_rlast) ? m_axi_rresp : 2'b10;
          state_d = RD_DONE;
        end
      end
      RD_DONE: begin
        if (s_axi_rready) begin
          last_wr_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Readies are gated by reset so nothing is granted while aresetn is held low.
  assign s_axi_awready = grant_wr & aresetn;
  assign s_axi_wready  = grant_wr & aresetn;
  assign s_axi_arready = grant_rd & aresetn;
  assign s_axi_bvalid  = (state_q == WR_DONE);
  assign s_axi_bresp   = resp_q;
  assign s_axi_rvalid  = (state_q == RD_DONE);
  assign s_axi_rresp   = resp_q;
  assign s_axi_rdata   = rdata_q;
  assign busy_o        = (state_q != IDLE);

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = (state_q == WR_REQ) & aw_pend_q;
  assign m_axi_awid    = ID_P;
  assign m_axi_awlock  = 2'b00;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awlen   = 4'd0;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = (state_q == WR_REQ) & w_pend_q;
  assign m_axi_wid     = ID_P;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_bready  = (state_q == WR_RESP);

  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = (state_q == RD_REQ);
  assign m_axi_arid    = ID_P;
  assign m_axi_arlock  = 2'b00;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arlen   = 4'd0;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_rready  = (state_q == RD_RESP);

endmodule

// File: tb/tb_zynq_axil_to_axi3_bridge.sv
// Bench for zynq_axil_to_axi3_bridge: directed and randomized host/slave traffic
// checked against an address/arbitration/response model kept in the bench.
module tb_zynq_axil_to_axi3_bridge;
  localparam logic [5:0]  ID       = 6'h2A;
  localparam logic [27:0] ATTR_EXP = {ID, 4'd0, 3'b010, 2'b01, 2'b00, 4'b0011, 3'b000, 4'd0};

  logic aclk = 1'b0, aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [31:0] base_addr_i, base;
  logic        busy_o;
  logic [29:0] s_axi_awaddr, s_axi_araddr;
  logic [2:0]  s_axi_awprot, s_axi_arprot;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [5:0]  m_axi_awid, m_axi_wid, m_axi_bid, m_axi_arid, m_axi_rid;
  logic [1:0]  m_axi_awlock, m_axi_awburst, m_axi_arlock, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic [3:0]  m_axi_awcache, m_axi_awlen, m_axi_awqos, m_axi_wstrb;
  logic [3:0]  m_axi_arcache, m_axi_arlen, m_axi_arqos;
  logic [2:0]  m_axi_awprot, m_axi_awsize, m_axi_arprot, m_axi_arsize;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rlast, m_axi_rready;

  assign base_addr_i = base;

  zynq_axil_to_axi3_bridge #(.S_ADDR_WIDTH_P(30), .M_ADDR_WIDTH_P(32), .DATA_WIDTH_P(32), .ID_P(ID)) dut (
    .aclk(aclk), .aresetn(aresetn), .base_addr_i(base_addr_i), .busy_o(busy_o),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awid(m_axi_awid),
    .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awqos(m_axi_awqos), .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wid(m_axi_wid), .m_axi_wlast(m_axi_wlast),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wready(m_axi_wready), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arid(m_axi_arid),
    .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arqos(m_axi_arqos), .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rid(m_axi_rid), .m_axi_rlast(m_axi_rlast),
    .m_axi_rresp(m_axi_rresp), .m_axi_rready(m_axi_rready)
  );

  int checks = 0, errors = 0;
  bit last_wr = 1'b0;   // model of arbitration history: 0 = read granted last (also after reset)

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [29:0] a);
    logic [63:0] sum;
    sum = {32'd0, base} + {34'd0, a};
    return sum[31:0];
  endfunction

  function automatic logic [1:0] exp_bresp(input logic [5:0] bid, input logic [1:0] br);
    return (bid == ID) ? br : 2'b10;
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [5:0] rid, input logic rl, input logic [1:0] rr);
    return (rid == ID && rl) ? rr : 2'b10;
  endfunction

  task automatic set_wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] st);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = st;
    s_axi_awprot = 3'($urandom); s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
  endtask

  task automatic set_rd(input logic [29:0] a);
    s_axi_araddr = a; s_axi_arprot = 3'($urandom); s_axi_arvalid = 1'b1;
  endtask

  task automatic wait_accept(output bit got_wr);
    bit done = 1'b0;
    got_wr = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge aclk); #1;
      if (s_axi_awready || s_axi_arready) begin
        chk("ready_exclusive", {s_axi_awready & s_axi_arready, s_axi_awready ^ s_axi_wready}, 2'b00);
        got_wr = s_axi_awready;
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
    @(posedge aclk); #1;
    if (got_wr) begin s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; end
    else s_axi_arvalid = 1'b0;
  endtask

  task automatic finish_wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] st,
                           input int aw_dly, input int w_dly, input logic [5:0] bid,
                           input logic [1:0] br, input int bready_dly);
    bit aw_done = 1'b0, w_done = 1'b0;
    for (int k = 0; k < 40 && !(aw_done && w_done); k++) begin
      m_axi_awready = !aw_done && k >= aw_dly;
      m_axi_wready  = !w_done && k >= w_dly;
      @(negedge aclk);
      chk("m_awvalid", m_axi_awvalid, !aw_done);
      chk("m_wvalid", m_axi_wvalid, !w_done);
      chk("busy_wr", busy_o, 1);
      chk("no_accept_busy", {s_axi_awready, s_axi_arready}, 0);
      if (!aw_done && m_axi_awready) begin
        chk("m_awaddr", m_axi_awaddr, exp_addr(a));
        chk("aw_attrs", {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                         m_axi_awcache, m_axi_awprot, m_axi_awqos}, ATTR_EXP);
        aw_done = 1'b1;
      end
      if (!w_done && m_axi_wready) begin
        chk("m_wdata", {m_axi_wdata, m_axi_wstrb, m_axi_wid, m_axi_wlast}, {d, st, ID, 1'b1});
        w_done = 1'b1;
      end
      @(posedge aclk); #1;
    end
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    if (!(aw_done && w_done)) chk("wr_req_timeout", 0, 1);
    m_axi_bvalid = 1'b1; m_axi_bid = bid; m_axi_bresp = br;
    @(negedge aclk);
    chk("m_bready", m_axi_bready, 1);
    @(posedge aclk); #1;
    m_axi_bvalid = 1'b0; m_axi_bid = 6'($urandom);
    for (int k = 0; k < 20; k++) begin
      s_axi_bready = (k >= bready_dly);
      @(negedge aclk);
      chk("s_bvalid_held", s_axi_bvalid, 1);
      chk("s_bresp", s_axi_bresp, exp_bresp(bid, br));
      if (s_axi_bready) break;
      @(posedge aclk); #1;
    end
    @(posedge aclk); #1;
    s_axi_bready = 1'b0;
    chk("s_bvalid_drop", s_axi_bvalid, 0);
    chk("idle_after_wr", busy_o, 0);
    last_wr = 1'b1;
  endtask

  task automatic finish_rd(input logic [29:0] a, input int ar_dly, input logic [31:0] rd,
                           input logic [5:0] rid, input logic rl, input logic [1:0] rr,
                           input int rready_dly);
    bit ar_done = 1'b0;
    for (int k = 0; k < 40 && !ar_done; k++) begin
      m_axi_arready = (k >= ar_dly);
      @(negedge aclk);
      chk("m_arvalid", m_axi_arvalid, 1);
      chk("busy_rd", busy_o, 1);
      chk("no_accept_busy", {s_axi_awready, s_axi_arready}, 0);
      if (m_axi_arready) begin
        chk("m_araddr", m_axi_araddr, exp_addr(a));
        chk("ar_attrs", {m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                         m_axi_arcache, m_axi_arprot, m_axi_arqos}, ATTR_EXP);
        ar_done = 1'b1;
      end
      @(posedge aclk); #1;
    end
    m_axi_arready = 1'b0;
    if (!ar_done) chk("rd_req_timeout", 0, 1);
    m_axi_rvalid = 1'b1; m_axi_rdata = rd; m_axi_rid = rid; m_axi_rlast = rl; m_axi_rresp = rr;
    @(negedge aclk);
    chk("m_rready", m_axi_rready, 1);
    @(posedge aclk); #1;
    m_axi_rvalid = 1'b0; m_axi_rdata = $urandom; m_axi_rid = 6'($urandom);
    for (int k = 0; k < 20; k++) begin
      s_axi_rready = (k >= rready_dly);
      @(negedge aclk);
      chk("s_rvalid_held", s_axi_rvalid, 1);
      chk("s_rdata", {s_axi_rdata, s_axi_rresp}, {rd, exp_rresp(rid, rl, rr)});
      if (s_axi_rready) break;
      @(posedge aclk); #1;
    end
    @(posedge aclk); #1;
    s_axi_rready = 1'b0;
    chk("s_rvalid_drop", s_axi_rvalid, 0);
    chk("idle_after_rd", busy_o, 0);
    last_wr = 1'b0;
  endtask

  task automatic do_wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] st,
                       input int awd, input int wd, input logic [5:0] bid, input logic [1:0] br,
                       input int bd);
    bit g;
    set_wr(a, d, st);
    wait_accept(g);
    chk("grant_wr", g, 1);
    finish_wr(a, d, st, awd, wd, bid, br, bd);
  endtask

  task automatic do_rd(input logic [29:0] a, input int ard, input logic [31:0] rd,
                       input logic [5:0] rid, input logic rl, input logic [1:0] rr, input int rd_dly);
    bit g;
    set_rd(a);
    wait_accept(g);
    chk("grant_rd", g, 0);
    finish_rd(a, ard, rd, rid, rl, rr, rd_dly);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] pw_a, pr_a;
    logic [31:0] pw_d;
    logic [3:0]  pw_s;
    bit g;
    base = 32'h1000_0000;
    {s_axi_awaddr, s_axi_araddr, s_axi_awprot, s_axi_arprot} = '0;
    {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_bready, s_axi_rready} = '0;
    s_axi_wdata = '0; s_axi_wstrb = '0;
    {m_axi_awready, m_axi_wready, m_axi_arready, m_axi_bvalid, m_axi_rvalid, m_axi_rlast} = '0;
    m_axi_bid = '0; m_axi_bresp = '0; m_axi_rid = '0; m_axi_rresp = '0; m_axi_rdata = '0;

    @(negedge aclk); #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_valids", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
                       m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    chk("rst_resp_data", {s_axi_rdata, s_axi_bresp, s_axi_rresp}, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // basic write and read
    do_wr(30'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, ID, 2'b00, 0);
    do_rd(30'h8, 0, 32'h1234_5678, ID, 1'b1, 2'b00, 0);

    // both pending continuously: grants must alternate starting with the one not granted last
    pw_a = 30'($urandom); pw_d = $urandom; pw_s = 4'($urandom); pr_a = 30'($urandom);
    set_wr(pw_a, pw_d, pw_s); set_rd(pr_a);
    for (int i = 0; i < 8; i++) begin
      bit exp_g;
      exp_g = !last_wr;
      wait_accept(g);
      chk("alt_grant", g, exp_g);
      if (g) begin
        finish_wr(pw_a, pw_d, pw_s, $urandom_range(0, 2), $urandom_range(0, 2), ID, 2'b00, $urandom_range(0, 2));
        pw_a = 30'($urandom); pw_d = $urandom; pw_s = 4'($urandom);
        if (i < 7) set_wr(pw_a, pw_d, pw_s);
      end else begin
        finish_rd(pr_a, $urandom_range(0, 2), $urandom, ID, 1'b1, 2'b00, $urandom_range(0, 2));
        pr_a = 30'($urandom);
        if (i < 7) set_rd(pr_a);
      end
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;

    // error responses: bad ids, missing rlast, and non-OKAY pass-through
    do_wr(30'h10, 32'hA5A5_0001, 4'h3, 0, 0, ID + 6'd1, 2'b00, 0);
    do_rd(30'h14, 0, 32'h0BAD_0001, ID, 1'b0, 2'b00, 0);
    do_rd(30'h18, 0, 32'h0BAD_0002, ID ^ 6'h01, 1'b1, 2'b00, 1);
    do_wr(30'h1C, 32'h0000_0001, 4'h1, 0, 0, ID, 2'b01, 0);
    do_rd(30'h20, 0, 32'hCAFE_0003, ID, 1'b1, 2'b11, 0);

    // wdata handshake well after address, host backpressure
    do_wr(30'h24, 32'h5555_AAAA, 4'hC, 0, 5, ID, 2'b00, $urandom_range(1, 4));
    do_wr(30'h28, 32'h7777_1111, 4'h6, 4, 1, ID, 2'b00, $urandom_range(1, 4));
    do_rd(30'h2C, 3, 32'h9999_8888, ID, 1'b1, 2'b00, $urandom_range(1, 4));

    // address wrap modulo 2^32
    base = 32'hFFFF_FFF0;
    do_wr(30'h20, 32'h0123_4567, 4'hF, 0, 0, ID, 2'b00, 0);
    do_rd(30'h3FFF_FFFF, 0, 32'h89AB_CDEF, ID, 1'b1, 2'b00, 0);

    // reset while waiting for the write response
    base = 32'h2000_0000;
    set_wr(30'h40, 32'hFEED_F00D, 4'hF);
    wait_accept(g);
    chk("rst_case_grant", g, 1);
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    @(negedge aclk);
    @(posedge aclk); #1;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    @(negedge aclk);
    chk("wr_resp_wait", m_axi_bready, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("midrst_valids", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
                          m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    chk("midrst_busy", busy_o, 0);
    last_wr = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("post_rst_no_bvalid", s_axi_bvalid, 0);
    do_wr(30'h44, 32'h1357_9BDF, 4'hA, 0, 0, ID, 2'b00, 0);

    // randomized traffic
    for (int i = 0; i < 16; i++) begin
      logic [5:0] id;
      base = $urandom;
      id = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ID;
      if ($urandom_range(0, 1) == 1)
        do_wr(30'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
              id, 2'($urandom), $urandom_range(0, 3));
      else
        do_rd(30'($urandom), $urandom_range(0, 3), $urandom, id, 1'($urandom_range(0, 4) != 0),
              2'($urandom), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
